// File: rtl/neighbour_window_if.sv
// ----------------------------------------------------------------------------
// neighbour_window_if
//   Bundles the field-memory read port and the neighbourhood output stream of
//   neighbour_window_gen.
//
//   Read port  : o_rd_en, o_rd_addr (row), i_rd_data (row word, one cycle later)
//   Stream     : o_valid / i_ready handshake carrying o_neighbours, o_cell,
//                o_x, o_y, o_last
//
//   master : the window generator
//   slave  : the consumer side (field memory + next-state rule)
// ----------------------------------------------------------------------------
interface neighbour_window_if #(
   parameter int WIDTH  = 16,
   parameter int HEIGHT = 16
);
   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);

   logic              o_rd_en;
   logic [YW-1:0]     o_rd_addr;
   logic [WIDTH-1:0]  i_rd_data;
   logic              o_valid;
   logic              i_ready;
   logic [7:0]        o_neighbours;
   logic              o_cell;
   logic [XW-1:0]     o_x;
   logic [YW-1:0]     o_y;
   logic              o_last;

   modport master (
      output o_rd_en, o_rd_addr, o_valid, o_neighbours, o_cell, o_x, o_y, o_last,
      input  i_rd_data, i_ready
   );

   modport slave (
      input  o_rd_en, o_rd_addr, o_valid, o_neighbours, o_cell, o_x, o_y, o_last,
      output i_rd_data, i_ready
   );
endinterface

// File: rtl/neighbour_window_gen.sv
// ----------------------------------------------------------------------------
// neighbour_window_gen
//   Streams the 3x3 toroidal neighbourhood of every cell of a WIDTH x HEIGHT
//   field, in raster order, to a next-state rule. The field memory is only
//   read: three row buffers (top/mid/bottom) hold rows y-1, y, y+1, and one
//   new row is fetched between output rows.
//
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : starts a generation (sampled only while idle)
//   o_busy         : high whenever not idle
//   o_done         : one-cycle pulse after the last beat
//   bus            : read port + output stream (neighbour_window_if.master)
// ----------------------------------------------------------------------------
module neighbour_window_gen #(
   parameter int WIDTH  = 16,
   parameter int HEIGHT = 16
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_start,
   output logic                o_busy,
   output logic                o_done,
   neighbour_window_if.master  bus
);
   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);
   localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

   typedef enum logic [2:0] {IDLE, LOAD, STREAM, FETCH, DONE} state_t;

   state_t            state, state_nxt;
   logic [1:0]        cnt;
   logic [XW-1:0]     x;
   logic [YW-1:0]     y;
   logic [WIDTH-1:0]  top_row, mid_row, bot_row;

   logic [XW-1:0]     x_m1, x_p1;
   logic [YW:0]       y_sum;
   logic [YW-1:0]     y_plus2;

   // Column neighbours with toroidal wrap.
   assign x_m1 = (x == '0)     ? X_LAST : x - XW'(1);
   assign x_p1 = (x == X_LAST) ? '0     : x + XW'(1);

   // Row to fetch for the next output row: (y + 2) mod HEIGHT.
   assign y_sum   = {1'b0, y} + (YW+1)'(2);
   assign y_plus2 = (y_sum >= (YW+1)'(HEIGHT)) ? YW'(y_sum - (YW+1)'(HEIGHT))
                                               : YW'(y_sum);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a signal unassigned, which would infer a latch.
      state_nxt     = state;
      bus.o_rd_en   = 1'b0;
      bus.o_rd_addr = '0;
      bus.o_valid   = 1'b0;
      o_done        = 1'b0;
      unique case (state)
         IDLE: if (i_start) state_nxt = LOAD;
         LOAD: begin
            // Counts 0..2 read rows HEIGHT-1, 0, 1; count 3 captures the last.
            bus.o_rd_en = (cnt != 2'd3);
            unique case (cnt)
               2'd0:    bus.o_rd_addr = Y_LAST;
               2'd1:    bus.o_rd_addr = '0;
               default: bus.o_rd_addr = YW'(1);
            endcase
            if (cnt == 2'd3) state_nxt = STREAM;
         end
         STREAM: begin
            bus.o_valid = 1'b1;
            if (bus.i_ready && x == X_LAST)
               state_nxt = (y == Y_LAST) ? DONE : FETCH;
         end
         FETCH: begin
            bus.o_rd_en   = (cnt == 2'd0);
            bus.o_rd_addr = y_plus2;
            if (cnt == 2'd1) state_nxt = STREAM;
         end
         DONE: begin
            o_done    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples values from before the edge, independent of statement order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         // NOTE: the row buffers are plain flops, not a RAM, so they are
         // cleared on reset like any other register.
         cnt     <= '0;
         x       <= '0;
         y       <= '0;
         top_row <= '0;
         mid_row <= '0;
         bot_row <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               cnt <= '0;
               if (i_start) begin
                  x <= '0;
                  y <= '0;
               end
            end
            LOAD: begin
               cnt <= cnt + 2'd1;
               unique case (cnt)
                  2'd1:    top_row <= bus.i_rd_data;
                  2'd2:    mid_row <= bus.i_rd_data;
                  2'd3:    bot_row <= bus.i_rd_data;
                  default: ;
               endcase
            end
            STREAM: begin
               cnt <= '0;
               if (bus.i_ready) x <= x_p1;
            end
            FETCH: begin
               cnt <= cnt + 2'd1;
               if (cnt == 2'd1) begin
                  top_row <= mid_row;
                  mid_row <= bot_row;
                  bot_row <= bus.i_rd_data;
                  y       <= y + YW'(1);
                  cnt     <= '0;
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

   assign o_busy           = (state != IDLE);
   assign bus.o_x          = x;
   assign bus.o_y          = y;
   assign bus.o_cell       = mid_row[x];
   assign bus.o_last       = bus.o_valid && (x == X_LAST) && (y == Y_LAST);
   assign bus.o_neighbours = {bot_row[x_p1], bot_row[x], bot_row[x_m1],
                              mid_row[x_p1],             mid_row[x_m1],
                              top_row[x_p1], top_row[x], top_row[x_m1]};
endmodule

// File: tb/tb_neighbour_window_gen.sv
// ----------------------------------------------------------------------------
// tb_neighbour_window_gen
//   Directed bench for neighbour_window_gen on a 4x4 field: reset values,
//   load/fetch read sequence, raster order and neighbourhoods, timing,
//   backpressure hold, ignored i_start, and asynchronous reset abort.
// ----------------------------------------------------------------------------
module tb_neighbour_window_gen;
   localparam int W = 4;
   localparam int H = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic busy, done;

   neighbour_window_if #(.WIDTH(W), .HEIGHT(H)) bus ();

   neighbour_window_gen #(.WIDTH(W), .HEIGHT(H)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_start (start),
      .o_busy  (busy),
      .o_done  (done),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Field memory model: one-cycle read latency.
   logic [W-1:0] mem [H];
   always @(posedge clk) if (bus.o_rd_en) bus.i_rd_data <= mem[bus.o_rd_addr];

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] got_nb   [16];
   logic       got_cell [16];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic cell_at(input int cx, input int cy);
      return mem[(cy + H) % H][(cx + W) % W];
   endfunction

   function automatic logic [7:0] model_nb(input int cx, input int cy);
      return {cell_at(cx+1, cy+1), cell_at(cx, cy+1), cell_at(cx-1, cy+1),
              cell_at(cx+1, cy),                      cell_at(cx-1, cy),
              cell_at(cx+1, cy-1), cell_at(cx, cy-1), cell_at(cx-1, cy-1)};
   endfunction

   // One generation. stall_beat: beat index held off for 3 cycles (-1 none);
   // poke: pulse i_start during beat 6; rst_beat: assert reset at that beat.
   task automatic run(input int stall_beat, input bit poke, input int rst_beat,
                      output int beats, output int dones, output int first, output int last_c);
      int idx = 0, stall = 0, done_cyc = -1;
      int la [3] = '{H-1, 0, 1};
      logic [31:0] snap = '0, cur;
      bit fin = 0;
      dones = 0; first = -1; last_c = -1;
      @(negedge clk);
      start = 1'b1;
      bus.i_ready = 1'b1;
      @(posedge clk);
      for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (first < 0 && bus.o_valid) first = cyc;
         if (cyc <= 3) check("ld_rd", {bus.o_rd_en, bus.o_rd_addr}, {1'b1, 2'(la[cyc-1])});
         if (cyc == 4) check("ld_end", bus.o_rd_en, 0);
         if (!bus.o_valid && cyc > 4 && !done && done_cyc < 0 && bus.o_rd_en)
            check("fetch_addr", bus.o_rd_addr, (idx / W + 1) % H);
         if (done) begin
            dones++;
            if (done_cyc < 0) done_cyc = cyc;
            check("done_lat", cyc, last_c + 1);
            check("done_valid", bus.o_valid, 0);
         end
         if (done_cyc >= 0 && cyc == done_cyc + 1) begin
            check("busy_off", busy, 0);
            fin = 1;
         end else if (bus.o_valid && idx == rst_beat) begin
            rst_n = 1'b0;
            #1;
            check("rst_async", {bus.o_valid, busy, bus.o_rd_en}, 0);
            fin = 1;
         end else if (bus.o_valid) begin
            cur = {20'd0, bus.o_x, bus.o_y, bus.o_neighbours, bus.o_cell, bus.o_last};
            if (idx == stall_beat && stall < 3) begin
               if (stall == 0) snap = cur;
               else check("hold", cur, snap);
               stall++;
               bus.i_ready = 1'b0;
            end else begin
               bus.i_ready = 1'b1;
            end
            if (poke && idx == 6) start = 1'b1;
            if (bus.i_ready) begin
               check("xy", {bus.o_x, bus.o_y}, {2'(idx % W), 2'(idx / W)});
               check("nb", bus.o_neighbours, model_nb(idx % W, idx / W));
               check("cell", bus.o_cell, mem[(idx / W) % H][idx % W]);
               check("last", bus.o_last, idx == W*H-1);
               check("rden_strm", bus.o_rd_en, 0);
               if (idx == stall_beat) check("hold_rel", cur, snap);
               if (idx < 16) begin
                  got_nb[idx]   = bus.o_neighbours;
                  got_cell[idx] = bus.o_cell;
               end
               if (bus.o_last) last_c = cyc;
               idx++;
            end
         end
      end
      if (!fin) check("timeout", 0, 1);
      beats = idx;
   endtask

   initial begin
      int beats, dones, first, last_c;
      bus.i_ready = 1'b1;
      foreach (mem[i]) mem[i] = '0;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_ctl", {bus.o_valid, bus.o_rd_en, busy, done, bus.o_last}, 0);
      check("rst_dat", {bus.o_x, bus.o_y, bus.o_rd_addr, bus.o_neighbours, bus.o_cell}, 0);
      rst_n = 1'b1;

      // Only (1,1) live; timing
      mem[1] = 4'b0010;
      run(-1, 0, -1, beats, dones, first, last_c);
      check("beats1", beats, 16);
      check("dones1", dones, 1);
      check("first_valid", first, 5);
      check("last_cyc", last_c, 26);
      check("nb_00_a", got_nb[0], 8'h80);
      check("cell_11", got_cell[5], 1);
      check("nb_11", got_nb[5], 8'h00);
      check("nb_22", got_nb[10], 8'h01);

      // Only (3,3) live; wrap
      mem[1] = 4'b0000;
      mem[3] = 4'b1000;
      run(-1, 0, -1, beats, dones, first, last_c);
      check("beats2", beats, 16);
      check("nb_00_b", got_nb[0], 8'h01);
      check("nb_30", got_nb[3], 8'h02);
      check("nb_03", got_nb[12], 8'h08);

      // Busier field; backpressure on beat (2,1)
      mem[0] = 4'b1011; mem[1] = 4'b0110; mem[2] = 4'b1100; mem[3] = 4'b0001;
      run(6, 0, -1, beats, dones, first, last_c);
      check("beats_stall", beats, 16);
      check("dones_stall", dones, 1);

      // i_start during STREAM is ignored
      run(-1, 1, -1, beats, dones, first, last_c);
      check("beats_poke", beats, 16);
      check("dones_poke", dones, 1);

      // Reset mid-row 2, then restart
      run(-1, 0, 9, beats, dones, first, last_c);
      check("beats_abort", beats, 9);
      repeat (2) @(negedge clk);
      check("rst_hold", {bus.o_valid, bus.o_rd_en, busy, done}, 0);
      rst_n = 1'b1;
      run(-1, 0, -1, beats, dones, first, last_c);
      check("beats_restart", beats, 16);
      check("dones_restart", dones, 1);
      check("first_restart", first, 5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
